tt_design_mux_ctrl: RTL and testbench
=====================================

# tt_design_mux_ctrl

Wishbone-programmable controller that selects one of `N_DESIGNS` user tiles on the Tiny Tapeout chip and sequences every switch safely. Outputs are forced to input (`io_oeb_force`), the new tile is held in reset, then it is released. It also generates a divided design clock. It sits between the Caravel wishbone port in `user_project_wrapper` and the tile mux inside `tt_top`, replacing the fixed single-design hookup.

## Interface
Parameters:
- `N_DESIGNS`, 16: number of selectable tiles; legal range 2..256.
- `SEL_W`, `$clog2(N_DESIGNS)`: select index width (derived).
- `RST_CYCLES`, 8: `wb_clk_i` cycles `design_rst` is held per switch; must be ≥1.
- `DIV_W`, 8: clock-divider register width.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: wishbone request.
- `wbs_adr_i` in 32: byte address; only bits [3:2] are decoded.
- `wbs_dat_i` in 32: write data; `wbs_sel_i` in 4 is ignored (full-word access only).
- `wbs_ack_o` out 1, `wbs_dat_o` out 32: response.
- `design_ena` out `N_DESIGNS`: one-hot tile enable, or all zero.
- `design_rst` out 1: reset to the selected tile, active-high.
- `design_clk` out 1: divided clock to the tiles.
- `io_oeb_force` out 1: when 1, the wrapper forces all `io_oeb` high.
- `active_sel` out `SEL_W`: index of the currently enabled tile.
- `user_irq` out 1: one-cycle pulse on each entry to RUN.

## Operation
Register map (word offsets):
- 0x0 SEL, R/W.
  - [SEL_W-1:0] = target index; [31] = enable.
  - A write starts a switch sequence.
- 0x4 CLKDIV, R/W, [DIV_W-1:0].
  - `design_clk` toggles every CLKDIV+1 cycles; 0 holds the clock low.
  - Reset value is 1.
  - A write clears the divider counter and drives `design_clk` low.
- 0x8 STATUS, RO.
  - [0] busy; [1] running; [2] dropped (sticky); [SEL_W+7:8] = `active_sel`.
  - A read clears bit [2].
- 0xC RSTCTL, WO.
  - Writing bit[0]=1 while in RUN re-runs QUIESCE→RESET on the same tile.
  - Other writes have no effect.

FSM states: IDLE, QUIESCE, RESET, RUN.
- IDLE: `design_ena`=0, `design_rst`=1, `io_oeb_force`=1.
- QUIESCE: lasts 2 cycles.
  - `io_oeb_force`=1; `design_ena` keeps its previous value; `design_rst`=1 from the first QUIESCE cycle.
- RESET: lasts RST_CYCLES cycles.
  - `design_ena`=one-hot(target); `active_sel`=target; `design_rst`=1; `io_oeb_force`=1.
- RUN: `design_rst`=0, `io_oeb_force`=0.

Transitions on a SEL write:
- If enable=1 and target<N_DESIGNS: go to QUIESCE, then RESET, then RUN.
- If enable=0 or target≥N_DESIGNS: go to QUIESCE, then IDLE; `active_sel` is unchanged.
- A SEL or RSTCTL write while busy (QUIESCE/RESET) is acked but ignored, and sets dropped=1.
- A SEL write in RUN to the same target still runs the full sequence.

Other rules:
- `design_clk` runs in every state, so tiles see clock edges during reset.
- Wishbone: `wbs_ack_o` is high exactly one cycle, in the cycle after the one where `stb&cyc` is sampled with ack low.
  - A request held high is acked every second cycle.
- `wbs_dat_o` is valid only with ack and is 0 otherwise. Unmapped offsets cannot exist (2-bit decode).
- Reset mid-sequence returns the block to IDLE within the same cycle edge and drops the sequence.

## Timing
- Reset values:
  - state IDLE, `design_ena`=0, `design_rst`=1, `io_oeb_force`=1.
  - `design_clk`=0, `active_sel`=0, `wbs_ack_o`=0, `wbs_dat_o`=0, `user_irq`=0.
  - SEL=0, CLKDIV=1, dropped=0.
- Write sampled at edge T:
  - ack is high in cycle T+1; state=QUIESCE from T+1.
  - RESET from T+3; RUN from T+3+RST_CYCLES.
  - `user_irq`=1 only in cycle T+3+RST_CYCLES.
- Total switch latency: 2+RST_CYCLES cycles after ack.
- `design_clk` period is 2·(CLKDIV+1) `wb_clk_i` cycles and is registered (glitch-free).

## Structure
- Package `tt_mux_pkg`: state enum (`ST_IDLE`, `ST_QUIESCE`, `ST_RESET`, `ST_RUN`), register offset constants, STATUS bit positions, QUIESCE length constant (2).
- Sub-module `tt_clk_div` (params `DIV_W`): inputs clk, rst, div, clear; output registered clock.
- Top level: wishbone decode, FSM, RST_CYCLES counter.

## Test plan
- Reset, then read STATUS → 0x0000_0000; CLKDIV read → 1; `io_oeb_force`=1, `design_ena`=0.
- Write SEL=0x8000_0005 at T → ack at T+1; `design_ena`=0x0020 from T+3; `design_rst` falls at T+3+RST_CYCLES; `user_irq` pulses once; STATUS=0x0000_0502.
- In RUN on tile 5, write SEL=0x8000_0007, then a second SEL write 2 cycles later → second write ignored; STATUS bit2=1, then reads 0 on the next read; final `design_ena`=0x0080.
- Write SEL=0x8000_0010 (index 16 ≥ N_DESIGNS) → QUIESCE then IDLE; `design_ena`=0; `io_oeb_force`=1; no irq.
- CLKDIV=3 → `design_clk` period 8 cycles; CLKDIV=0 → `design_clk` stays 0.
- Assert `wb_rst_i` during RESET → next cycle in IDLE, `design_ena`=0, no irq; RSTCTL write in RUN re-enters RESET on the same tile.

Source files
------------

// File: rtl/tt_mux_pkg.sv
// Shared types and constants for the Tiny Tapeout design-select controller.
package tt_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_RESET   = 2'd2,
    ST_RUN     = 2'd3
  } mux_state_t;

  // Word offsets, decoded from wbs_adr_i[3:2]
  localparam logic [1:0] ADR_SEL    = 2'd0;
  localparam logic [1:0] ADR_CLKDIV = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;
  localparam logic [1:0] ADR_RSTCTL = 2'd3;

  // STATUS register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_RUNNING = 1;
  localparam int STAT_DROPPED = 2;
  localparam int STAT_SEL_LSB = 8;

  // Cycles spent with outputs forced to input before touching the tile enable
  localparam int QUIESCE_LEN = 2;

  // A switch sequence is in flight; register writes that would start one are dropped
  function automatic logic is_busy(input mux_state_t s);
    return (s == ST_QUIESCE) || (s == ST_RESET);
  endfunction

endpackage

// File: rtl/tt_clk_div.sv
// Registered divided clock: toggles every (div+1) input cycles, held low when div==0.
module tt_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_clear,
  output logic             o_clk
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_clk;

  // Count up to div, then toggle; clear/zero divisor park the clock low
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {DIV_W{1'b0}};
      r_clk <= 1'b0;
    end else if (i_clear || (i_div == {DIV_W{1'b0}})) begin
      r_cnt <= {DIV_W{1'b0}};
      r_clk <= 1'b0;
    end else if (r_cnt == i_div) begin
      r_cnt <= {DIV_W{1'b0}};
      r_clk <= ~r_clk;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  assign o_clk = r_clk;

endmodule

// File: rtl/tt_design_mux_ctrl.sv
// Wishbone-programmed tile selector: quiesces IOs, resets the new tile, then releases it.
module tt_design_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int N_DESIGNS  = 16,
  parameter int SEL_W      = $clog2(N_DESIGNS),
  parameter int RST_CYCLES = 8,
  parameter int DIV_W      = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [N_DESIGNS-1:0] design_ena,
  output logic                 design_rst,
  output logic                 design_clk,
  output logic                 io_oeb_force,
  output logic [SEL_W-1:0]     active_sel,
  output logic                 user_irq
);

  localparam int CNT_W = $clog2(RST_CYCLES + QUIESCE_LEN) + 1;

  mux_state_t           r_state, w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [SEL_W-1:0]     r_target, r_active, r_sel_idx;
  logic                 r_sel_en, r_go_run, r_dropped;
  logic [DIV_W-1:0]     r_div;
  logic                 r_ack;
  logic [31:0]          r_dat;
  logic [N_DESIGNS-1:0] r_ena;
  logic                 r_rst, r_oeb, r_irq;

  logic                 w_req, w_wr, w_rd, w_busy;
  logic [1:0]           w_adr;
  logic                 w_wr_sel, w_wr_rstctl, w_wr_clkdiv;
  logic                 w_sel_ok, w_rstctl_ok, w_start, w_drop, w_sel_valid;
  logic [31:0]          w_rdata, w_status;
  logic [N_DESIGNS-1:0] w_onehot, w_ena_nxt;
  logic [SEL_W-1:0]     w_active_nxt;
  logic                 w_rst_nxt, w_oeb_nxt, w_irq_nxt;
  logic                 w_unused_bits;

  // Byte lanes and undecoded address bits are intentionally ignored
  assign w_unused_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  // A request is taken only while ack is low, so a held request is served every other cycle
  assign w_req       = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr        = w_req & wbs_we_i;
  assign w_rd        = w_req & ~wbs_we_i;
  assign w_adr       = wbs_adr_i[3:2];
  assign w_busy      = is_busy(r_state);
  assign w_wr_sel    = w_wr && (w_adr == ADR_SEL);
  assign w_wr_rstctl = w_wr && (w_adr == ADR_RSTCTL);
  assign w_wr_clkdiv = w_wr && (w_adr == ADR_CLKDIV);
  // The whole index field above the enable bit counts, so out-of-range targets park in IDLE
  assign w_sel_valid = wbs_dat_i[31] && ({1'b0, wbs_dat_i[30:0]} < 32'(N_DESIGNS));
  assign w_sel_ok    = w_wr_sel && !w_busy;
  assign w_rstctl_ok = w_wr_rstctl && !w_busy && wbs_dat_i[0] && (r_state == ST_RUN);
  assign w_drop      = w_busy && (w_wr_sel || w_wr_rstctl);
  assign w_start     = w_sel_ok || w_rstctl_ok;
  assign w_onehot    = {{(N_DESIGNS-1){1'b0}}, 1'b1} << r_target;

  // Software-visible registers and the latched switch request
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sel_en  <= 1'b0;
      r_sel_idx <= {SEL_W{1'b0}};
      r_target  <= {SEL_W{1'b0}};
      r_go_run  <= 1'b0;
      r_div     <= DIV_W'(1);
      r_dropped <= 1'b0;
    end else begin
      if (w_sel_ok) begin
        r_sel_en  <= wbs_dat_i[31];
        r_sel_idx <= wbs_dat_i[SEL_W-1:0];
        r_target  <= wbs_dat_i[SEL_W-1:0];
        r_go_run  <= w_sel_valid;
      end else if (w_rstctl_ok) begin
        r_target  <= r_active;
        r_go_run  <= 1'b1;
      end
      if (w_wr_clkdiv) begin
        r_div <= wbs_dat_i[DIV_W-1:0];
      end
      if (w_drop) begin
        r_dropped <= 1'b1;
      end else if (w_rd && (w_adr == ADR_STATUS)) begin
        r_dropped <= 1'b0;
      end
    end
  end

  // Read data mux; RSTCTL is write-only and reads as zero
  always_comb begin
    w_status = 32'd0;
    w_status[STAT_BUSY]    = w_busy;
    w_status[STAT_RUNNING] = (r_state == ST_RUN);
    w_status[STAT_DROPPED] = r_dropped;
    w_status[STAT_SEL_LSB +: SEL_W] = r_active;
    w_rdata = 32'd0;
    case (w_adr)
      ADR_SEL:    w_rdata = {r_sel_en, {(31-SEL_W){1'b0}}, r_sel_idx};
      ADR_CLKDIV: w_rdata = {{(32-DIV_W){1'b0}}, r_div};
      ADR_STATUS: w_rdata = w_status;
      ADR_RSTCTL: w_rdata = 32'd0;
      default:    w_rdata = 32'd0;
    endcase
  end

  // Single-cycle ack; data is zero outside the ack cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;
    end
  end

  // State register; reset abandons any sequence in flight
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Dwell counter, restarted on every state change
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == w_next) && w_busy) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= {CNT_W{1'b0}};
    end
  end

  // Next-state logic for the switch sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_QUIESCE;
        else         w_next = ST_IDLE;
      end
      ST_QUIESCE: begin
        if (r_cnt == CNT_W'(QUIESCE_LEN - 1)) w_next = r_go_run ? ST_RESET : ST_IDLE;
        else                                  w_next = ST_QUIESCE;
      end
      ST_RESET: begin
        if (r_cnt == CNT_W'(RST_CYCLES - 1)) w_next = ST_RUN;
        else                                 w_next = ST_RESET;
      end
      ST_RUN: begin
        if (w_start) w_next = ST_QUIESCE;
        else         w_next = ST_RUN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output values for the coming state; registered below so the tile sees clean levels
  always_comb begin
    w_ena_nxt    = r_ena;
    w_active_nxt = r_active;
    case (w_next)
      ST_IDLE:    w_ena_nxt = {N_DESIGNS{1'b0}};
      ST_QUIESCE: w_ena_nxt = r_ena;
      ST_RESET: begin
        w_ena_nxt    = w_onehot;
        w_active_nxt = r_target;
      end
      ST_RUN:     w_ena_nxt = r_ena;
      default:    w_ena_nxt = {N_DESIGNS{1'b0}};
    endcase
    w_rst_nxt = (w_next != ST_RUN);
    w_oeb_nxt = (w_next != ST_RUN);
    w_irq_nxt = (w_next == ST_RUN) && (r_state != ST_RUN);
  end

  // Output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ena    <= {N_DESIGNS{1'b0}};
      r_active <= {SEL_W{1'b0}};
      r_rst    <= 1'b1;
      r_oeb    <= 1'b1;
      r_irq    <= 1'b0;
    end else begin
      r_ena    <= w_ena_nxt;
      r_active <= w_active_nxt;
      r_rst    <= w_rst_nxt;
      r_oeb    <= w_oeb_nxt;
      r_irq    <= w_irq_nxt;
    end
  end

  tt_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_div   (r_div),
    .i_clear (w_wr_clkdiv),
    .o_clk   (design_clk)
  );

  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;
  assign design_ena   = r_ena;
  assign design_rst   = r_rst;
  assign io_oeb_force = r_oeb;
  assign active_sel   = r_active;
  assign user_irq     = r_irq;

endmodule

// File: tb/tb_tt_design_mux_ctrl.sv
// Directed bench for the design-select controller (N_DESIGNS=16, RST_CYCLES=8).
module tb_tt_design_mux_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] ena;
  logic        drst, dclk, oeb, irq;
  logic [3:0]  asel;

  int n_pass  = 0;
  int n_total = 0;

  tt_design_mux_ctrl #(.N_DESIGNS(16), .RST_CYCLES(8), .DIV_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .design_ena(ena), .design_rst(drst), .design_clk(dclk), .io_oeb_force(oeb),
    .active_sel(asel), .user_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus transfer; returns in the ack cycle with the number of edges waited (8+ = no ack)
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d;
    lat = 0;
    rd  = 32'd0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      lat++;
      if (ack) break;
    end
    if (!ack) lat = 99;
    rd  = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; int lat;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; adr = 32'd0; dat = 32'd0;
    step(3);
    n_total++; if (ena !== 16'h0) $display("FAIL rst_ena: got %h want %h", ena, 16'h0); else n_pass++;
    n_total++; if ({drst, oeb, dclk, irq, ack} !== 5'b11000) $display("FAIL rst_outs: got %b want %b", {drst, oeb, dclk, irq, ack}, 5'b11000); else n_pass++;
    n_total++; if ({asel, rdat} !== 36'd0) $display("FAIL rst_sel_dat: got %h want %h", {asel, rdat}, 36'd0); else n_pass++;
    rst = 1'b0;
    step(1);
    wb_xfer(1'b0, 32'h8, 32'd0, rd, lat);
    n_total++; if (rd !== 32'h0) $display("FAIL rst_status: got %h want %h", rd, 32'h0); else n_pass++;
    step(1);
    wb_xfer(1'b0, 32'h4, 32'd0, rd, lat);
    n_total++; if (rd !== 32'h1) $display("FAIL rst_clkdiv: got %h want %h", rd, 32'h1); else n_pass++;
    step(1);
    n_total++; if (rdat !== 32'h0) $display("FAIL dat_idle_zero: got %h want %h", rdat, 32'h0); else n_pass++;
  endtask

  task automatic test_switch;
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, 32'h0, 32'h8000_0005, rd, lat);                  // cycle T+1
    n_total++; if (lat !== 1) $display("FAIL sw_ack_lat: got %0d want %0d", lat, 1); else n_pass++;
    n_total++; if ({ena, oeb, drst} !== {16'h0, 2'b11}) $display("FAIL sw_quiesce: got %h want %h", {ena, oeb, drst}, {16'h0, 2'b11}); else n_pass++;
    step(1);                                                        // T+2
    n_total++; if (ena !== 16'h0) $display("FAIL sw_quiesce2_ena: got %h want %h", ena, 16'h0); else n_pass++;
    step(1);                                                        // T+3
    n_total++; if ({ena, asel, drst} !== {16'h0020, 4'd5, 1'b1}) $display("FAIL sw_reset_entry: got %h want %h", {ena, asel, drst}, {16'h0020, 4'd5, 1'b1}); else n_pass++;
    step(7);                                                        // T+10
    n_total++; if ({drst, irq} !== 2'b10) $display("FAIL sw_reset_last: got %b want %b", {drst, irq}, 2'b10); else n_pass++;
    step(1);                                                        // T+11
    n_total++; if ({drst, oeb, irq} !== 3'b001) $display("FAIL sw_run_entry: got %b want %b", {drst, oeb, irq}, 3'b001); else n_pass++;
    step(1);
    n_total++; if (irq !== 1'b0) $display("FAIL sw_irq_once: got %b want %b", irq, 1'b0); else n_pass++;
    wb_xfer(1'b0, 32'h8, 32'd0, rd, lat);
    n_total++; if (rd !== 32'h0000_0502) $display("FAIL sw_status: got %h want %h", rd, 32'h0000_0502); else n_pass++;
    step(1);
    wb_xfer(1'b0, 32'h0, 32'd0, rd, lat);
    n_total++; if (rd !== 32'h8000_0005) $display("FAIL sw_sel_rb: got %h want %h", rd, 32'h8000_0005); else n_pass++;
    step(1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, 32'h0, 32'h8000_0007, rd, lat);
    wb_xfer(1'b1, 32'h0, 32'h8000_0009, rd, lat);                  // lands during QUIESCE
    n_total++; if (lat !== 2) $display("FAIL b2b_ack_lat: got %0d want %0d", lat, 2); else n_pass++;
    step(12);
    wb_xfer(1'b0, 32'h8, 32'd0, rd, lat);
    n_total++; if (rd !== 32'h0000_0706) $display("FAIL b2b_status_drop: got %h want %h", rd, 32'h0000_0706); else n_pass++;
    step(1);
    wb_xfer(1'b0, 32'h8, 32'd0, rd, lat);
    n_total++; if (rd !== 32'h0000_0702) $display("FAIL b2b_status_clr: got %h want %h", rd, 32'h0000_0702); else n_pass++;
    n_total++; if ({ena, drst} !== {16'h0080, 1'b0}) $display("FAIL b2b_ena: got %h want %h", {ena, drst}, {16'h0080, 1'b0}); else n_pass++;
    step(1);
  endtask

  task automatic test_invalid;
    logic [31:0] rd; int lat; int irqs;
    wb_xfer(1'b1, 32'h0, 32'h8000_0010, rd, lat);                  // T+1
    step(1);                                                        // T+2
    n_total++; if ({ena, oeb, drst} !== {16'h0080, 2'b11}) $display("FAIL inv_quiesce: got %h want %h", {ena, oeb, drst}, {16'h0080, 2'b11}); else n_pass++;
    irqs = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (irq) irqs++;
    end
    n_total++; if ({ena, oeb, drst, asel} !== {16'h0, 2'b11, 4'd7}) $display("FAIL inv_idle: got %h want %h", {ena, oeb, drst, asel}, {16'h0, 2'b11, 4'd7}); else n_pass++;
    n_total++; if (irqs !== 0) $display("FAIL inv_no_irq: got %0d want %0d", irqs, 0); else n_pass++;
    wb_xfer(1'b0, 32'h8, 32'd0, rd, lat);
    n_total++; if (rd !== 32'h0000_0700) $display("FAIL inv_status: got %h want %h", rd, 32'h0000_0700); else n_pass++;
    step(1);
  endtask

  task automatic test_clkdiv;
    logic [31:0] rd; int lat;
    logic [15:0] got, exp;
    wb_xfer(1'b1, 32'h4, 32'd3, rd, lat);
    for (int k = 0; k < 16; k++) begin
      got[k] = dclk;
      exp[k] = ((k / 4) % 2) == 1;
      step(1);
    end
    n_total++; if (got !== exp) $display("FAIL clkdiv3_wave: got %b want %b", got, exp); else n_pass++;
    wb_xfer(1'b0, 32'h4, 32'd0, rd, lat);
    n_total++; if (rd !== 32'd3) $display("FAIL clkdiv3_rb: got %h want %h", rd, 32'd3); else n_pass++;
    step(1);
    wb_xfer(1'b1, 32'h4, 32'd0, rd, lat);
    for (int k = 0; k < 16; k++) begin
      got[k] = dclk;
      step(1);
    end
    n_total++; if (got !== 16'h0) $display("FAIL clkdiv0_low: got %b want %b", got, 16'h0); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int lat; int irqs;
    wb_xfer(1'b1, 32'h0, 32'h8000_0003, rd, lat);
    step(2);                                                        // in RESET
    n_total++; if ({ena, drst} !== {16'h0008, 1'b1}) $display("FAIL mid_in_reset: got %h want %h", {ena, drst}, {16'h0008, 1'b1}); else n_pass++;
    rst = 1'b1;
    step(1);
    n_total++; if ({ena, drst, oeb, asel, irq} !== {16'h0, 2'b11, 4'd0, 1'b0}) $display("FAIL mid_idle: got %h want %h", {ena, drst, oeb, asel, irq}, {16'h0, 2'b11, 4'd0, 1'b0}); else n_pass++;
    rst = 1'b0;
    irqs = 0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (irq) irqs++;
    end
    n_total++; if ({irqs, ena, drst} !== {32'd0, 16'h0, 1'b1}) $display("FAIL mid_stays_idle: got %h want %h", {irqs, ena, drst}, {32'd0, 16'h0, 1'b1}); else n_pass++;
  endtask

  task automatic test_rstctl;
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, 32'h0, 32'h8000_0002, rd, lat);
    step(11);
    n_total++; if ({ena, drst, asel} !== {16'h0004, 1'b0, 4'd2}) $display("FAIL rc_run: got %h want %h", {ena, drst, asel}, {16'h0004, 1'b0, 4'd2}); else n_pass++;
    wb_xfer(1'b1, 32'hC, 32'h0, rd, lat);                          // bit0 clear: no effect
    step(3);
    n_total++; if ({drst, oeb} !== 2'b00) $display("FAIL rc_noop: got %b want %b", {drst, oeb}, 2'b00); else n_pass++;
    wb_xfer(1'b1, 32'hC, 32'h1, rd, lat);                          // T+1
    n_total++; if ({drst, oeb} !== 2'b11) $display("FAIL rc_quiesce: got %b want %b", {drst, oeb}, 2'b11); else n_pass++;
    step(2);                                                        // T+3
    n_total++; if ({ena, asel, drst} !== {16'h0004, 4'd2, 1'b1}) $display("FAIL rc_reset: got %h want %h", {ena, asel, drst}, {16'h0004, 4'd2, 1'b1}); else n_pass++;
    step(8);                                                        // T+11
    n_total++; if ({drst, irq} !== 2'b01) $display("FAIL rc_rerun: got %b want %b", {drst, irq}, 2'b01); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_back_to_back();
    test_invalid();
    test_clkdiv();
    test_reset_mid();
    test_rstctl();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
